// File: rtl/mips_mc.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc
// Brief    : Multicycle MIPS subset core (lw, sw, add, sub, and, or, slt,
//            beq, addi, j) with a unified memory port and debug readout.
//            Optional macro MIPS_MC_BNE_EN adds bne (opcode 05h).
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic              halted,
    input  logic [4:0]        dbg_sel,
    output logic [31:0]       dbg_data
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
`ifdef MIPS_MC_BNE_EN
    localparam logic [5:0] c_op_bne   = 6'h05;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic [31:0] r_mdr;
    logic [31:0] r_rf [32];

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;
    logic [31:0] w_alu_r;
    logic        w_funct_ok;
    logic        w_taken;
    logic [31:0] w_addr;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};

`ifdef MIPS_MC_BNE_EN
    // bne shares the BEQEX state; only the taken condition is inverted.
    assign w_taken = (w_op == c_op_bne) ? (r_a != r_b) : (r_a == r_b);
`else
    assign w_taken = (r_a == r_b);
`endif

    assign pc        = r_pc;
    assign halted    = (r_state == TRAP);
    assign mem_wdata = r_b;
    assign mem_addr  = w_addr[ADDR_W-1:0];
    assign dbg_data  = (dbg_sel == 5'd0) ? 32'd0 : r_rf[dbg_sel];

    // R-type ALU: result plus a flag for funct codes the core implements.
    always_comb begin
        w_alu_r    = 32'd0;
        w_funct_ok = 1'b1;
        case (w_funct)
            6'h20:   w_alu_r = r_a + r_b;
            6'h22:   w_alu_r = r_a - r_b;
            6'h24:   w_alu_r = r_a & r_b;
            6'h25:   w_alu_r = r_a | r_b;
            6'h2A:   w_alu_r = {31'd0, ($signed(r_a) < $signed(r_b))};
            default: w_funct_ok = 1'b0;
        endcase
    end

    // State register; reset always restarts at FETCH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and memory-port decode; reset masks any pending access.
    always_comb begin
        w_next  = r_state;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        w_addr  = r_aluout;
        case (r_state)
            FETCH: begin
                mem_req = 1'b1;
                w_addr  = r_pc;
                if (mem_ready) w_next = DECODE;
            end
            DECODE: begin
                case (w_op)
                    c_op_lw, c_op_sw: w_next = MEMADR;
                    c_op_rtype:       w_next = RTYPEEX;
                    c_op_beq:         w_next = BEQEX;
`ifdef MIPS_MC_BNE_EN
                    c_op_bne:         w_next = BEQEX;
`endif
                    c_op_addi:        w_next = ADDIEX;
                    c_op_j:           w_next = JEX;
                    default:          w_next = TRAP;
                endcase
            end
            MEMADR:  w_next = (w_op == c_op_sw) ? MEMWR : MEMRD;
            MEMRD: begin
                mem_req = 1'b1;
                if (mem_ready) w_next = MEMWB;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) w_next = FETCH;
            end
            RTYPEEX: w_next = w_funct_ok ? RTYPEWB : TRAP;
            ADDIEX:  w_next = ADDIWB;
            MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX: w_next = FETCH;
            TRAP:    w_next = TRAP;
            default: w_next = FETCH;
        endcase
        if (!reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    // Datapath registers and register file; $0 writes are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_aluout <= 32'd0;
            r_mdr    <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                DECODE: begin
                    r_a      <= r_rf[w_rs];
                    r_b      <= r_rf[w_rt];
                    r_aluout <= r_pc + {w_simm[29:0], 2'b00};
                end
                MEMADR, ADDIEX: r_aluout <= r_a + w_simm;
                MEMRD: begin
                    if (mem_ready) r_mdr <= mem_rdata;
                end
                MEMWB: begin
                    if (w_rt != 5'd0) r_rf[w_rt] <= r_mdr;
                end
                RTYPEEX: r_aluout <= w_alu_r;
                RTYPEWB: begin
                    if (w_rd != 5'd0) r_rf[w_rd] <= r_aluout;
                end
                ADDIWB: begin
                    if (w_rt != 5'd0) r_rf[w_rt] <= r_aluout;
                end
                BEQEX: begin
                    if (w_taken) r_pc <= r_aluout;
                end
                JEX: r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc
// Brief    : Scoreboard bench for mips_mc; expected memory transactions are
//            queued by the stimulus and checked by an independent monitor.
//            Expectations for opcode 05h follow macro MIPS_MC_BNE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b1;
    logic [31:0] pc;
    logic        halted;
    logic [4:0]  dbg_sel = 5'd0;
    logic [31:0] dbg_data;

    mips_mc #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc       (pc),
        .halted   (halted),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Memory: program image from stimulus, stored words tagged by phase.
    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    int          dval [256];
    int          phase = 1;
    logic        stall_all = 1'b0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_len = 0;

    assign mem_rdata = (dval[mem_addr[9:2]] == phase) ? dmem[mem_addr[9:2]]
                                                      : imem[mem_addr[9:2]];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          we;
        bit          isf;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
    } txn_t;
    txn_t exq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic push_f(input logic [31:0] a, input int gap);
        txn_t t;
        t.we = 1'b0; t.isf = 1'b1; t.addr = a; t.wdata = 32'd0; t.gap = gap;
        exq.push_back(t);
    endtask

    task automatic push_r(input logic [31:0] a);
        txn_t t;
        t.we = 1'b0; t.isf = 1'b0; t.addr = a; t.wdata = 32'd0; t.gap = -1;
        exq.push_back(t);
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = 1'b1; t.isf = 1'b0; t.addr = a; t.wdata = d; t.gap = -1;
        exq.push_back(t);
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        imem[a[9:2]] = w;
    endtask

    task automatic chk_reg(input logic [4:0] r, input logic [31:0] exp);
        dbg_sel = r;
        #1;
        chk($sformatf("dbg r%0d", r), dbg_data, exp);
    endtask

    // Enter reset for two cycles and open a new phase.
    task automatic start_phase();
        reset = 1'b0;
        phase++;
        exq.delete();
        repeat (2) @(negedge clk);
        chk1("halted cleared in reset", halted, 1'b0);
    endtask

    // Release reset and wait (bounded) until the core halts.
    task automatic run_to_halt(input int budget);
        reset = 1'b1;
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        chk1("halt reached", halted, 1'b1);
        @(negedge clk);
        chk("scoreboard left", exq.size(), 32'd0);
    endtask

    // Halted core must stay idle with pc frozen.
    task automatic chk_idle(input logic [31:0] exp_pc);
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0) bad++;
        end
        chk("mem_req while halted", bad, 32'd0);
        chk("pc frozen", pc, exp_pc);
        chk1("still halted", halted, 1'b1);
    endtask

    // Memory responder: ready decided just after each rising edge.
    initial begin : resp
        int wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_all) begin
                mem_ready = 1'b0;
            end else if (mem_req && !mem_we && mem_addr == stall_addr && wait_cnt < stall_len) begin
                mem_ready = 1'b0;
                wait_cnt++;
            end else begin
                mem_ready = 1'b1;
                if (!(mem_req && !mem_we && mem_addr == stall_addr)) wait_cnt = 0;
            end
        end
    end

    // Monitor: every completing access is popped and compared.
    initial begin : mon
        int   cyc = 0;
        int   last_f = 0;
        txn_t t;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (reset && mem_req && mem_ready) begin
                if (mem_we) begin
                    dmem[mem_addr[9:2]] = mem_wdata;
                    dval[mem_addr[9:2]] = phase;
                end
                if (exq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected access: got addr %h we %b, expected none", mem_addr, mem_we);
                end else begin
                    t = exq.pop_front();
                    chk("access addr", mem_addr, t.addr);
                    chk1("access we", mem_we, t.we);
                    if (t.we) chk("store data", mem_wdata, t.wdata);
                    if (t.isf) begin
                        if (t.gap >= 0) chk("instr cycles", cyc - last_f, t.gap);
                        last_f = cyc;
                    end
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'hFC00_0000;
            dmem[i] = 32'd0;
        end

        // Reset behaviour and held fetch.
        reset     = 1'b0;
        stall_all = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset pc", pc, 32'h0000_0100);
        chk1("reset mem_req", mem_req, 1'b0);
        chk1("reset mem_we", mem_we, 1'b0);
        chk1("reset halted", halted, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk1("first req", mem_req, 1'b1);
        chk("first addr", mem_addr, 32'h0000_0100);
        chk1("first halted", halted, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("stalled fetch pc", pc, 32'h0000_0100);
        chk1("stalled fetch req", mem_req, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("req masked by reset", mem_req, 1'b0);
        stall_all = 1'b0;

        // Phase 1: addi/addi/add, sw then lw with 3 wait cycles, trap 3Fh.
        start_phase();
        put(32'h100, 32'h2001_0005);
        put(32'h104, 32'h2002_0007);
        put(32'h108, 32'h0022_1820);
        put(32'h10C, 32'hAC03_0008);
        put(32'h110, 32'h8C04_0008);
        put(32'h114, 32'hFC00_0000);
        stall_addr = 32'h0000_0008;
        stall_len  = 3;
        push_f(32'h100, -1);
        push_f(32'h104, 4);
        push_f(32'h108, 4);
        push_f(32'h10C, 4);
        push_w(32'h008, 32'd12);
        push_f(32'h110, 4);
        push_r(32'h008);
        push_f(32'h114, 8);
        run_to_halt(200);
        chk_reg(5'd1, 32'd5);
        chk_reg(5'd2, 32'd7);
        chk_reg(5'd3, 32'd12);
        chk_reg(5'd4, 32'd12);
        chk_idle(32'h0000_0118);

        // Phase 2: j, beq taken/not taken, R-type ops, $0 write, bad funct.
        start_phase();
        stall_addr = 32'hFFFF_FFFF;
        stall_len  = 0;
        put(32'h108, 32'h0800_0004);
        put(32'h010, 32'h1021_0002);
        put(32'h01C, 32'h1022_0005);
        put(32'h020, 32'h0022_2822);
        put(32'h024, 32'h0022_3024);
        put(32'h028, 32'h0022_3825);
        put(32'h02C, 32'h00A1_402A);
        put(32'h030, 32'h0025_482A);
        put(32'h034, 32'h2020_0009);
        put(32'h038, 32'h20AA_FFFD);
        put(32'h03C, 32'h0000_0021);
        push_f(32'h100, -1);
        push_f(32'h104, 4);
        push_f(32'h108, 4);
        push_f(32'h010, 3);
        push_f(32'h01C, 3);
        push_f(32'h020, 3);
        push_f(32'h024, 4);
        push_f(32'h028, 4);
        push_f(32'h02C, 4);
        push_f(32'h030, 4);
        push_f(32'h034, 4);
        push_f(32'h038, 4);
        push_f(32'h03C, 4);
        run_to_halt(200);
        chk("pc after bad funct", pc, 32'h0000_0040);
        chk_reg(5'd0, 32'd0);
        chk_reg(5'd5, 32'hFFFF_FFFE);
        chk_reg(5'd6, 32'd5);
        chk_reg(5'd7, 32'd7);
        chk_reg(5'd8, 32'd1);
        chk_reg(5'd9, 32'd0);
        chk_reg(5'd10, 32'hFFFF_FFFB);

        // Phase 3: bne $1,$2,+1.
        start_phase();
        put(32'h108, 32'h1422_0001);
        put(32'h10C, 32'hFC00_0000);
        put(32'h110, 32'hFC00_0000);
        push_f(32'h100, -1);
        push_f(32'h104, 4);
        push_f(32'h108, 4);
`ifdef MIPS_MC_BNE_EN
        push_f(32'h110, 3);
        run_to_halt(200);
        chk_idle(32'h0000_0114);
`else
        run_to_halt(200);
        chk_idle(32'h0000_010C);
`endif

        // Reset leaves the trap state.
        reset = 1'b0;
        @(negedge clk);
        chk1("halted after reset", halted, 1'b0);
        chk("pc after reset", pc, 32'h0000_0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
